// File: rtl/adder_operand_sequencer.sv
// rtl/adder_operand_sequencer.sv - operand FIFO and multicycle-path sequencer around a ripple carry adder
// Define ADDER_SEQ_OVF_FLAG_EN to add the registered signed-overflow output out_ovf.
module adder_operand_sequencer #(
  parameter int WIDTH         = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
`ifdef ADDER_SEQ_OVF_FLAG_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(SETTLE_CYCLES + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  logic [WIDTH-1:0] mem_x [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_y [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             capture;
  logic             release_out;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // A pop in the same cycle never frees a slot for a push when full.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= in_x;
      mem_y[wr_ptr] <= in_y;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pop         = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cnt_next   = CW'(SETTLE_CYCLES);
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CW'(1)) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          // Reload straight from HOLD so a streaming source sees no idle bubble.
          if (!empty) begin
            pop        = 1'b1;
            cnt_next   = CW'(SETTLE_CYCLES);
            state_next = SETTLE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      add_x     <= '0;
      add_y     <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_valid <= 1'b0;
`ifdef ADDER_SEQ_OVF_FLAG_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (pop) begin
        add_x <= mem_x[rd_ptr];
        add_y <= mem_y[rd_ptr];
      end
      if (capture) begin
        out_sum   <= add_s;
        out_carry <= add_co;
        out_valid <= 1'b1;
`ifdef ADDER_SEQ_OVF_FLAG_EN
        out_ovf   <= (add_x[MSB] == add_y[MSB]) && (add_s[MSB] != add_x[MSB]);
`endif
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// tb/tb_adder_operand_sequencer.sv - scoreboard testbench for adder_operand_sequencer
module tb_adder_operand_sequencer;

  localparam int W      = 32;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int AW     = $clog2(DEPTH);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic [W-1:0] add_s;
  logic         add_co;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         busy;
  logic         ovf_obs;
`ifdef ADDER_SEQ_OVF_FLAG_EN
  logic         out_ovf;
  assign ovf_obs = out_ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  adder_operand_sequencer #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .add_x(add_x), .add_y(add_y), .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
`ifdef ADDER_SEQ_OVF_FLAG_EN
    .out_ovf(out_ovf),
`endif
    .busy(busy)
  );

  // Adder stand-in: output is inverted garbage during the first cycle after its inputs change.
  logic [W-1:0] prev_x = '0;
  logic [W-1:0] prev_y = '0;
  logic [W:0]   true_sum;
  logic         settled;
  always @(posedge clk) begin
    prev_x <= add_x;
    prev_y <= add_y;
  end
  assign true_sum = {1'b0, add_x} + {1'b0, add_y};
  assign settled  = (add_x == prev_x) && (add_y == prev_y);
  assign add_s    = settled ? true_sum[W-1:0] : ~true_sum[W-1:0];
  assign add_co   = settled ? true_sum[W] : ~true_sum[W];

  logic [W+1:0] exp_q [$];
  int           out_cyc_q [$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           n_out    = 0;
  int           n_acc    = 0;

  logic [W-1:0] b2b_x [3] = '{32'd1, 32'd3, 32'h80000000};
  logic [W-1:0] b2b_y [3] = '{32'd2, 32'd4, 32'h80000000};

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    logic       ovf;
    s = {1'b0, x} + {1'b0, y};
`ifdef ADDER_SEQ_OVF_FLAG_EN
    ovf = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`else
    ovf = 1'b0;
`endif
    return {ovf, s};
  endfunction

  // One clock: record accepted pairs, score any result handshake, land at posedge+1.
  task automatic step();
    logic [W+1:0] e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_x, in_y));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      checks++;
      n_out++;
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got ovf/carry/sum=%h with no result pending", {ovf_obs, out_carry, out_sum});
      end else begin
        e = exp_q.pop_front();
        if ({ovf_obs, out_carry, out_sum} !== e) begin
          failures++;
          $display("FAIL sb_result: got ovf/carry/sum=%h expected %h", {ovf_obs, out_carry, out_sum}, e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags: got ready/valid/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({add_x, add_y} !== '0) begin
      failures++;
      $display("FAIL reset_operands: got add_x=%h add_y=%h expected 0", add_x, add_y);
    end
    checks++;
    if ({out_carry, out_sum} !== '0) begin
      failures++;
      $display("FAIL reset_result: got carry=%b sum=%h expected 0", out_carry, out_sum);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'hFFFFFFFF; in_y = 32'h00000001;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if ({add_x, add_y, out_valid} !== {32'hFFFFFFFF, 32'h00000001, 1'b0}) begin
      failures++;
      $display("FAIL single_load_e1: got add_x=%h add_y=%h valid=%b", add_x, add_y, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_e2: got out_valid=%b expected 0", out_valid);
    end
    step();
    checks++;
    if ({out_valid, out_carry, out_sum} !== {1'b1, 1'b1, 32'h00000000}) begin
      failures++;
      $display("FAIL single_result_e3: got valid=%b carry=%b sum=%h expected 1 1 00000000", out_valid, out_carry, out_sum);
    end
    step();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL single_idle: got busy=%b out_valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    out_ready = 1'b1;
    out_cyc_q.delete();
    base = n_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = b2b_x[i]; in_y = b2b_y[i];
      step();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 40 && n_out < base + 3; t++) step();
    checks++;
    if (n_out - base != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d results expected 3", n_out - base);
    end else begin
      checks++;
      if (out_cyc_q[1] - out_cyc_q[0] != SETTLE + 1 || out_cyc_q[2] - out_cyc_q[1] != SETTLE + 1) begin
        failures++;
        $display("FAIL b2b_spacing: got gaps %0d %0d expected %0d", out_cyc_q[1] - out_cyc_q[0], out_cyc_q[2] - out_cyc_q[1], SETTLE + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int           acc0;
    int           base;
    logic [W-1:0] held_sum;
    logic         held_carry;
    bit           stable;
    out_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_x = $urandom; in_y = $urandom;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (n_acc - acc0 != DEPTH + 1) begin
      failures++;
      $display("FAIL bp_accepted: got %0d pairs expected %0d", n_acc - acc0, DEPTH + 1);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_in_ready: got %b expected 0", in_ready);
    end
    held_sum = out_sum; held_carry = out_carry; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_sum !== held_sum || out_carry !== held_carry || out_valid !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_hold_stable: got sum=%h valid=%b expected sum=%h valid=1", out_sum, out_valid, held_sum);
    end
    out_ready = 1'b1;
    base = n_out;
    for (int t = 0; t < 60 && n_out < base + DEPTH + 1; t++) step();
    checks++;
    if (n_out - base != DEPTH + 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: got %0d results with %0d pending expected %0d with 0", n_out - base, exp_q.size(), DEPTH + 1);
    end
  endtask

  task automatic test_wrap();
    int acc0;
    int base;
    int pre;
    bit count_ok;
    out_ready = 1'b0;
    acc0 = n_acc;
    base = n_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = $urandom; in_y = $urandom;
      step();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 10 && !out_valid; t++) step();
    out_ready = 1'b1;
    count_ok = 1'b1;
    for (int t = 0; t < 80 && (n_acc - acc0) < 12; t++) begin
      in_valid = out_valid; in_x = $urandom; in_y = $urandom;
      pre = n_acc;
      step();
      if (n_acc != pre && dut.count !== (AW+1)'(2)) count_ok = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (n_acc - acc0 != 12 || !count_ok) begin
      failures++;
      $display("FAIL wrap_push_pop: got %0d pushes count_held=%b expected 12 and 1", n_acc - acc0, count_ok);
    end
    for (int t = 0; t < 60 && n_out < base + 12; t++) step();
    checks++;
    if (n_out - base != 12 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain: got %0d results with %0d pending expected 12 with 0", n_out - base, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_x = $urandom; in_y = $urandom;
      step();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 10 && !out_valid; t++) step();
    out_ready = 1'b1; in_valid = 1'b1; in_x = $urandom; in_y = $urandom;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b011) begin
      failures++;
      $display("FAIL rstmid_pre: got valid/busy/ready=%b expected 011", {out_valid, busy, in_ready});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL rstmid_async: got valid/ready/busy=%b expected 010", {out_valid, in_ready, busy});
    end
    checks++;
    if ({add_x, add_y, out_carry, out_sum} !== '0) begin
      failures++;
      $display("FAIL rstmid_regs: got add_x=%h add_y=%h sum=%h expected 0", add_x, add_y, out_sum);
    end
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rstmid_stale: got %0d active cycles after reset expected 0", seen);
    end
  endtask

`ifdef ADDER_SEQ_OVF_FLAG_EN
  task automatic test_ovf();
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 32'h7FFFFFFF; in_y = 32'h00000001;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 10 && !out_valid; t++) step();
    checks++;
    if ({out_valid, out_ovf, out_carry, out_sum} !== {1'b1, 1'b1, 1'b0, 32'h80000000}) begin
      failures++;
      $display("FAIL ovf_set: got valid=%b ovf=%b carry=%b sum=%h expected 1 1 0 80000000", out_valid, out_ovf, out_carry, out_sum);
    end
    step();
    in_valid = 1'b1; in_x = 32'hFFFFFFFF; in_y = 32'h00000001;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 10 && !out_valid; t++) step();
    checks++;
    if ({out_valid, out_ovf, out_carry, out_sum} !== {1'b1, 1'b0, 1'b1, 32'h00000000}) begin
      failures++;
      $display("FAIL ovf_clear: got valid=%b ovf=%b carry=%b sum=%h expected 1 0 1 00000000", out_valid, out_ovf, out_carry, out_sum);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef ADDER_SEQ_OVF_FLAG_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
